trace_capture_unit: RTL

- Synthesizable on-chip trace buffer for the pipelined CPU; replaces bench-only per-cycle logging with hardware capture.
- Records register-writeback and data-memory-write events, each stamped with a cycle count and PC, into a parametrised circular buffer.
- Detects pipeline drain (program end), then stops capture.
- Buffer is read out through a valid/ready port; sits beside the CPU and taps its WB and MEM stages.

---
 rtl/trace_pkg.sv | 48 ++++
 rtl/trace_fifo.sv | 58 +++++
 rtl/trace_capture_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the trace capture unit: FSM states, event kinds and
// the bit layout of one buffered trace entry.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int KIND_W = 2;
    localparam logic [KIND_W-1:0] KIND_REG  = 2'b01;
    localparam logic [KIND_W-1:0] KIND_MEM  = 2'b10;
    localparam logic [KIND_W-1:0] KIND_BOTH = 2'b11;

    // Entry layout, MSB to LSB: {cycle, pc, kind, wb_addr, wb_data, mw_addr, mw_data}
    function automatic int entry_w(input int cnt_w, input int pc_w, input int reg_aw,
                                   input int data_w, input int mem_aw);
        return cnt_w + pc_w + KIND_W + reg_aw + data_w + mem_aw + data_w;
    endfunction

    function automatic int off_mw_addr(input int data_w);
        return data_w;
    endfunction

    function automatic int off_wb_data(input int data_w, input int mem_aw);
        return data_w + mem_aw;
    endfunction

    function automatic int off_wb_addr(input int data_w, input int mem_aw);
        return 2 * data_w + mem_aw;
    endfunction

    function automatic int off_kind(input int data_w, input int mem_aw, input int reg_aw);
        return 2 * data_w + mem_aw + reg_aw;
    endfunction

    function automatic int off_pc(input int data_w, input int mem_aw, input int reg_aw);
        return 2 * data_w + mem_aw + reg_aw + KIND_W;
    endfunction

    function automatic int off_cycle(input int data_w, input int mem_aw, input int reg_aw,
                                     input int pc_w);
        return 2 * data_w + mem_aw + reg_aw + KIND_W + pc_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace buffer; pointers carry one extra MSB so full and empty differ.
// The head entry reads straight from storage and is forced to zero while empty.
module trace_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int WRAP_MODE = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overwrite
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wrap_en;
    logic             do_pop;
    logic             do_write;
    logic             adv_rd;

    assign wrap_en   = (WRAP_MODE != 0);
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count     = wr_ptr - rd_ptr;
    assign do_pop    = pop & ~empty;
    assign do_write  = push & (~full | do_pop | wrap_en);
    // Full with no pop in wrap mode: the write lands on the oldest slot, so the head moves too.
    assign overwrite = push & full & ~do_pop & wrap_en;
    assign adv_rd    = do_pop | overwrite;
    assign rdata     = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (adv_rd)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/trace_capture_unit.sv
// On-chip trace capture: stamps WB register writes and MEM stores with cycle and PC,
// buffers them, and stops a fixed number of cycles after the pipeline drains.
//
// state   | meaning
// IDLE    | waiting for start; counter held
// CAPTURE | recording events; watching for pipeline drain
// DRAIN   | still recording for DRAIN_CYCLES cycles
// DONE    | capture finished; readout only, until clear
module trace_capture_unit
    import trace_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 5,
    parameter int MEM_AW       = 32,
    parameter int PC_W         = 32,
    parameter int CNT_W        = 32,
    parameter int DEPTH        = 64,
    parameter int WRAP_MODE    = 1,
    parameter int DRAIN_CYCLES = 2,
    parameter int SKIP_R0      = 1,
    localparam int ENTRY_W     = entry_w(CNT_W, PC_W, REG_AW, DATA_W, MEM_AW),
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               start,
    input  logic               clear,
    input  logic               ex_valid,
    input  logic               mem_valid,
    input  logic [PC_W-1:0]    wb_pc,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               mw_en,
    input  logic [MEM_AW-1:0]  mw_addr,
    input  logic [DATA_W-1:0]  mw_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [CW-1:0]      count,
    output logic [15:0]        overflow_cnt,
    output logic [1:0]         state,
    output logic               done
);

    localparam int O_MW_ADDR = off_mw_addr(DATA_W);
    localparam int O_WB_DATA = off_wb_data(DATA_W, MEM_AW);
    localparam int O_WB_ADDR = off_wb_addr(DATA_W, MEM_AW);
    localparam int O_KIND    = off_kind(DATA_W, MEM_AW, REG_AW);
    localparam int O_PC      = off_pc(DATA_W, MEM_AW, REG_AW);
    localparam int O_CYCLE   = off_cycle(DATA_W, MEM_AW, REG_AW, PC_W);
    localparam int TW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t             state_q, state_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic [CNT_W-1:0]   cyc_q;
    logic [15:0]        ovf_q;
    logic               active;
    logic               ev_reg;
    logic               ev_mem;
    logic               push;
    logic [ENTRY_W-1:0] entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_ovw;
    logic               lost;

    assign active = (state_q == CAPTURE) || (state_q == DRAIN);
    assign ev_reg = wb_en & ~((SKIP_R0 != 0) && (wb_addr == '0));
    assign ev_mem = mw_en;
    assign push   = (ev_reg | ev_mem) & active & ~clear;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = CAPTURE;
                CAPTURE: if (mem_valid && !ex_valid) begin
                    state_d = DRAIN;
                    tmr_d   = TMR_LOAD;
                end
                DRAIN:   if (tmr_q == '0) state_d = DONE;
                         else tmr_d = tmr_q - 1'b1;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cyc_q <= '0;
        end else if (clear || (state_q == IDLE && state_d == CAPTURE)) begin
            cyc_q <= '0;
        end else if (active) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    // The entry carries the cycle value seen during the event, before this edge's increment.
    always_comb begin
        entry = '0;
        entry[O_CYCLE +: CNT_W]  = cyc_q;
        entry[O_PC +: PC_W]      = wb_pc;
        entry[O_KIND +: KIND_W]  = {ev_mem, ev_reg};
        if (ev_reg) begin
            entry[O_WB_ADDR +: REG_AW] = wb_addr;
            entry[O_WB_DATA +: DATA_W] = wb_data;
        end
        if (ev_mem) begin
            entry[O_MW_ADDR +: MEM_AW] = mw_addr;
            entry[0 +: DATA_W]         = mw_data;
        end
    end

    trace_fifo #(
        .WIDTH     (ENTRY_W),
        .DEPTH     (DEPTH),
        .WRAP_MODE (WRAP_MODE)
    ) u_fifo (
        .clk       (CLOCK),
        .rst_n     (RESET),
        .clear     (clear),
        .push      (push),
        .wdata     (entry),
        .pop       (rd_ready),
        .rdata     (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count),
        .overwrite (fifo_ovw)
    );

    // Overwrites come from the buffer; drops are full-without-pop pushes in non-wrap mode.
    assign lost = fifo_ovw | (push & fifo_full & ~(rd_ready & ~fifo_empty));

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            ovf_q <= '0;
        end else if (clear) begin
            ovf_q <= '0;
        end else if (lost && ovf_q != 16'hFFFF) begin
            ovf_q <= ovf_q + 1'b1;
        end
    end

    assign rd_valid     = ~fifo_empty;
    assign overflow_cnt = ovf_q;
    assign state        = state_q;
    assign done         = (state_q == DONE);

endmodule
